quad_pulse_counter: RTL and testbench

QUAD_PULSE_COUNTER -- requirements
Module: quad_pulse_counter

---
 rtl/quad_pkg.sv | 37 +++
 rtl/quad_input_filter.sv | 49 ++++
 rtl/quad_pulse_counter.sv | 135 +++++++++++++
 tb/tb_quad_pulse_counter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared encodings and helpers for the quadrature pulse counter.
package quad_pkg;

   localparam int unsigned DEF_COUNT_W    = 16;
   localparam int unsigned DEF_SPEED_W    = 8;
   localparam int unsigned DEF_FILTER_LEN = 3;

   // Encoded as {A,B}
   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } quad_state_e;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2
   } step_e;

   function automatic quad_state_e fwd_next(input quad_state_e s);
      case (s)
         S00:     return S10;
         S10:     return S11;
         S11:     return S01;
         default: return S00;
      endcase
   endfunction

   function automatic step_e decode_step(input quad_state_e prev, input quad_state_e cur);
      if (cur == fwd_next(prev)) return STEP_FWD;
      if (prev == fwd_next(cur)) return STEP_REV;
      return STEP_NONE;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser with an optional stable-sample glitch filter,
// enabled by defining QUAD_GLITCH_FILTER_EN.
module quad_input_filter
   import quad_pkg::*;
#(
   parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_in,
   output logic o_level
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= 2'b00;
      else          r_sync <= {r_sync[0], i_in};
   end

`ifdef QUAD_GLITCH_FILTER_EN
   logic [3:0] r_cnt;
   logic       r_level;

   // Counts consecutive samples that disagree with the accepted level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= 4'd0;
         r_level <= 1'b0;
      end else if (r_sync[1] == r_level) begin
         r_cnt <= 4'd0;
      end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
         r_level <= r_sync[1];
         r_cnt   <= 4'd0;
      end else begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign o_level = r_level;
`else
   // FILTER_LEN has no effect in this build.
   if (FILTER_LEN > 15) begin : g_filter_len_ignored
   end

   assign o_level = r_sync[1];
`endif

endmodule

// File: rtl/quad_pulse_counter.sv
// Quadrature encoder decoder: X1/X4 position count, windowed signed speed, sticky error.
// Define QUAD_GLITCH_FILTER_EN to add the input glitch filter.
module quad_pulse_counter
   import quad_pkg::*;
#(
   parameter int unsigned COUNT_W    = DEF_COUNT_W,
   parameter int unsigned SPEED_W    = DEF_SPEED_W,
   parameter bit          FWD        = 1'b1,
   parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_enc_a,
   input  logic               i_enc_b,
   input  logic               i_mode,
   input  logic               i_clear,
   input  logic               i_speed_interval_pulse,
   output logic [COUNT_W-1:0] o_count,
   output logic [SPEED_W-1:0] o_speed_count,
   output logic               o_dir_out,
   output logic               o_valid,
   output logic               o_err
);

   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Assert asynchronously, release on the clock.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   logic w_a;
   logic w_b;

   quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
      .i_clk   (i_clk),
      .i_rst_n (w_rst_n),
      .i_in    (i_enc_a),
      .o_level (w_a)
   );

   quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
      .i_clk   (i_clk),
      .i_rst_n (w_rst_n),
      .i_in    (i_enc_b),
      .o_level (w_b)
   );

   quad_state_e               r_prev;
   quad_state_e               w_cur;
   step_e                     w_step;
   logic                      w_illegal;
   logic signed [SPEED_W:0]   w_delta;
   logic signed [SPEED_W:0]   w_sum;
   logic signed [SPEED_W-1:0] w_acc_sat;
   logic signed [SPEED_W-1:0] r_acc;
   logic signed [SPEED_W-1:0] r_speed;
   logic [COUNT_W-1:0]        r_count;
   logic                      r_dir;
   logic                      r_valid;
   logic                      r_err;

   always_comb begin
      w_cur     = quad_state_e'({w_a, w_b});
      w_illegal = (r_prev[1] ^ w_cur[1]) & (r_prev[0] ^ w_cur[0]);
      w_step    = decode_step(r_prev, w_cur);
      // X1 keeps only steps taken on a rising A
      if (!i_mode && !(!r_prev[1] && w_cur[1])) w_step = STEP_NONE;
   end

   always_comb begin
      w_delta = '0;
      case (w_step)
         STEP_FWD: w_delta = (SPEED_W+1)'(1);
         STEP_REV: w_delta = '1;
         default:  w_delta = '0;
      endcase
      w_sum = {r_acc[SPEED_W-1], r_acc} + w_delta;
      if (w_sum[SPEED_W] != w_sum[SPEED_W-1]) begin
         w_acc_sat = w_sum[SPEED_W] ? {1'b1, {(SPEED_W-1){1'b0}}} : {1'b0, {(SPEED_W-1){1'b1}}};
      end else begin
         w_acc_sat = w_sum[SPEED_W-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_prev  <= S00;
         r_count <= '0;
         r_acc   <= '0;
         r_speed <= '0;
         r_dir   <= FWD;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_prev  <= w_cur;
         r_valid <= i_en & ~i_clear & (w_step != STEP_NONE);

         if (i_speed_interval_pulse) begin
            r_speed <= w_acc_sat;
            r_acc   <= '0;
         end else if (i_clear) begin
            r_acc <= '0;
         end else begin
            r_acc <= w_acc_sat;
         end

         if (i_clear) begin
            r_count <= '0;
            r_err   <= 1'b0;
         end else begin
            if (w_step == STEP_FWD) begin
               r_count <= r_count + COUNT_W'(1);
               r_dir   <= FWD;
            end else if (w_step == STEP_REV) begin
               r_count <= r_count - COUNT_W'(1);
               r_dir   <= ~FWD;
            end
            if (w_illegal) r_err <= 1'b1;
         end
      end
   end

   assign o_count       = r_count;
   assign o_speed_count = r_speed;
   assign o_dir_out     = r_dir;
   assign o_valid       = r_valid;
   assign o_err         = r_err;

endmodule

// File: tb/tb_quad_pulse_counter.sv
// Directed self-checking bench for quad_pulse_counter.
module tb_quad_pulse_counter;

   localparam int unsigned COUNT_W    = 16;
   localparam int unsigned SPEED_W    = 8;
   localparam int unsigned FILTER_LEN = 3;
`ifdef QUAD_GLITCH_FILTER_EN
   localparam int LAT = 3 + FILTER_LEN;
`else
   localparam int LAT = 3;
`endif
   localparam int HOLD = 6;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               enc_a;
   logic               enc_b;
   logic               mode;
   logic               clear;
   logic               sip;
   logic [COUNT_W-1:0] count;
   logic [SPEED_W-1:0] speed;
   logic               dir;
   logic               valid;
   logic               err;

   int total = 0;
   int bad = 0;
   int valid_cnt = 0;
   int v0;

   quad_pulse_counter #(
      .COUNT_W    (COUNT_W),
      .SPEED_W    (SPEED_W),
      .FWD        (1'b1),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_en                   (en),
      .i_enc_a                (enc_a),
      .i_enc_b                (enc_b),
      .i_mode                 (mode),
      .i_clear                (clear),
      .i_speed_interval_pulse (sip),
      .o_count                (count),
      .o_speed_count          (speed),
      .o_dir_out              (dir),
      .o_valid                (valid),
      .o_err                  (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (valid === 1'b1) valid_cnt++;

   task automatic set_ab(input logic a, input logic b);
      @(negedge clk);
      enc_a = a;
      enc_b = b;
      repeat (HOLD - 1) @(negedge clk);
   endtask

   task automatic fwd_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_ab(1'b1, 1'b0);
         set_ab(1'b1, 1'b1);
         set_ab(1'b0, 1'b1);
         set_ab(1'b0, 1'b0);
      end
   endtask

   task automatic rev_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_ab(1'b0, 1'b1);
         set_ab(1'b1, 1'b1);
         set_ab(1'b1, 1'b0);
         set_ab(1'b0, 1'b0);
      end
   endtask

   task automatic settle();
      repeat (LAT + 2) @(negedge clk);
   endtask

   task automatic pulse_sip();
      @(negedge clk);
      sip = 1'b1;
      @(negedge clk);
      sip = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      enc_a = 1'b0;
      enc_b = 1'b0;
      clear = 1'b0;
      sip   = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1; enc_a = 1'b0; enc_b = 1'b0; mode = 1'b1; clear = 1'b0; sip = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0h exp=0", count); end
      total++; if (speed !== 8'd0) begin bad++; $display("FAIL rst_speed got=%0h exp=0", speed); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL rst_dir got=%0b exp=1", dir); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_latency();
      do_reset();
      mode = 1'b1;
      @(negedge clk);
      enc_a = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1;
      total++; if (count !== 16'd0) begin bad++; $display("FAIL lat_early got=%0h exp=0", count); end
      @(posedge clk);
      #1;
      total++; if (count !== 16'd1) begin bad++; $display("FAIL lat_edge got=%0h exp=1", count); end
      settle();
   endtask

   task automatic test_x4_fwd();
      do_reset();
      mode = 1'b1;
      v0 = valid_cnt;
      fwd_cycles(4);
      settle();
      total++; if (count !== 16'd16) begin bad++; $display("FAIL x4_count got=%0h exp=10", count); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL x4_dir got=%0b exp=1", dir); end
      total++; if (valid_cnt - v0 !== 16) begin bad++; $display("FAIL x4_valid got=%0d exp=16", valid_cnt - v0); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL x4_err got=%0b exp=0", err); end
   endtask

   task automatic test_x1_rev();
      do_reset();
      mode = 1'b0;
      v0 = valid_cnt;
      rev_cycles(3);
      settle();
      total++; if (count !== 16'hFFFD) begin bad++; $display("FAIL x1_count got=%0h exp=fffd", count); end
      total++; if (valid_cnt - v0 !== 3) begin bad++; $display("FAIL x1_valid got=%0d exp=3", valid_cnt - v0); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL x1_err got=%0b exp=0", err); end
      total++; if (dir !== 1'b0) begin bad++; $display("FAIL x1_dir got=%0b exp=0", dir); end
   endtask

   task automatic test_illegal();
      do_reset();
      mode = 1'b1;
      v0 = valid_cnt;
      fwd_cycles(1);
      set_ab(1'b1, 1'b1);
      settle();
      total++; if (count !== 16'd4) begin bad++; $display("FAIL ill_count got=%0h exp=4", count); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%0b exp=1", err); end
      total++; if (valid_cnt - v0 !== 4) begin bad++; $display("FAIL ill_valid got=%0d exp=4", valid_cnt - v0); end
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err got=%0b exp=0", err); end
      total++; if (count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0h exp=0", count); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL clr_dir got=%0b exp=1", dir); end
      total++; if (valid_cnt - v0 !== 4) begin bad++; $display("FAIL clr_valid got=%0d exp=4", valid_cnt - v0); end
   endtask

   // Continues from state 11 left by test_illegal.
   task automatic test_en_low();
      en = 1'b0;
      v0 = valid_cnt;
      set_ab(1'b0, 1'b1);
      set_ab(1'b0, 1'b0);
      settle();
      total++; if (count !== 16'd2) begin bad++; $display("FAIL enlow_count got=%0h exp=2", count); end
      total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL enlow_valid got=%0d exp=0", valid_cnt - v0); end
      en = 1'b1;
   endtask

   task automatic test_speed();
      do_reset();
      mode = 1'b1;
      fwd_cycles(50);
      settle();
      total++; if (count !== 16'd200) begin bad++; $display("FAIL spd_count got=%0h exp=c8", count); end
      pulse_sip();
      @(negedge clk);
      total++; if (speed !== 8'd127) begin bad++; $display("FAIL spd_sat got=%0h exp=7f", speed); end
      set_ab(1'b0, 1'b1);
      set_ab(1'b1, 1'b1);
      set_ab(1'b1, 1'b0);
      set_ab(1'b0, 1'b0);
      set_ab(1'b0, 1'b1);
      settle();
      pulse_sip();
      @(negedge clk);
      total++; if (speed !== 8'hFB) begin bad++; $display("FAIL spd_rev got=%0h exp=fb", speed); end
      total++; if (count !== 16'd195) begin bad++; $display("FAIL spd_count2 got=%0h exp=c3", count); end
      set_ab(1'b0, 1'b0);
      set_ab(1'b1, 1'b0);
      settle();
      @(negedge clk);
      clear = 1'b1;
      sip   = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      sip   = 1'b0;
      @(negedge clk);
      total++; if (speed !== 8'd2) begin bad++; $display("FAIL clrsip_speed got=%0h exp=2", speed); end
      total++; if (count !== 16'd0) begin bad++; $display("FAIL clrsip_count got=%0h exp=0", count); end
      pulse_sip();
      @(negedge clk);
      total++; if (speed !== 8'd0) begin bad++; $display("FAIL clrsip_acc got=%0h exp=0", speed); end
   endtask

   task automatic test_async_reset();
      do_reset();
      mode = 1'b1;
      fwd_cycles(1);
      settle();
      pulse_sip();
      @(negedge clk);
      total++; if (speed !== 8'd4) begin bad++; $display("FAIL ar_speed_pre got=%0h exp=4", speed); end
      set_ab(1'b0, 1'b1);
      settle();
      total++; if (dir !== 1'b0) begin bad++; $display("FAIL ar_dir_pre got=%0b exp=0", dir); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (count !== 16'd0) begin bad++; $display("FAIL ar_count got=%0h exp=0", count); end
      total++; if (speed !== 8'd0) begin bad++; $display("FAIL ar_speed got=%0h exp=0", speed); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL ar_dir got=%0b exp=1", dir); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0b exp=0", valid); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ar_err got=%0b exp=0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 6) @(negedge clk);
      // Inputs still at 01: first decode sees a legal 00->01 reverse step.
      total++; if (count !== 16'hFFFF) begin bad++; $display("FAIL ar_first got=%0h exp=ffff", count); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ar_first_err got=%0b exp=0", err); end
      pulse_sip();
      @(negedge clk);
      total++; if (speed !== 8'hFF) begin bad++; $display("FAIL ar_window got=%0h exp=ff", speed); end
   endtask

   task automatic test_glitch();
      do_reset();
      mode = 1'b1;
      v0 = valid_cnt;
      @(negedge clk);
      enc_a = 1'b1;
      repeat (2) @(negedge clk);
      enc_a = 1'b0;
      repeat (LAT + 6) @(negedge clk);
      total++; if (count !== 16'd0) begin bad++; $display("FAIL glitch_count got=%0h exp=0", count); end
`ifdef QUAD_GLITCH_FILTER_EN
      total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
      enc_a = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      total++; if (count !== 16'd1) begin bad++; $display("FAIL filt_step got=%0h exp=1", count); end
`else
      total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL glitch_valid got=%0d exp=2", valid_cnt - v0); end
`endif
   endtask

   initial begin
      test_reset();
      test_latency();
      test_x4_fwd();
      test_x1_rev();
      test_illegal();
      test_en_low();
      test_speed();
      test_async_reset();
      test_glitch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
